// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// uart_rx_fifo : oversampled UART receiver feeding an error-tagged RX FIFO
// Revision     : 1.0
// ============================================================================
module uart_rx_fifo #(
  parameter int FIFO_DEPTH  = 16,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    word_length,
  input  logic [15:0]                   baud_div,
  input  logic [2:0]                    parity,
  input  logic                          rx,
  input  logic                          read_flag,
  input  logic                          fifo_clear,
  input  logic [1:0]                    trig_level,
  output logic [7:0]                    po_rx_data,
  output logic                          parity_error,
  output logic                          framing_error,
  output logic                          break_int,
  output logic                          data_ready,
  output logic                          overrun_error,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          rx_int,
  output logic                          rx_busy
);

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int SCW = $clog2(OVERSAMPLE);

  localparam logic [SCW-1:0] MID_LO = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] MID    = SCW'(OVERSAMPLE / 2);
  localparam logic [SCW-1:0] MID_HI = SCW'(OVERSAMPLE / 2 + 1);
  localparam logic [SCW-1:0] LAST   = SCW'(OVERSAMPLE - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_PARITY    = 3'd3;
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_WAIT_HIGH = 3'd5;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [2:0]             state_q, state_d;
  logic [15:0]            div_cnt_q, div_cnt_d;
  logic [15:0]            baud_q, baud_d;
  logic [SCW-1:0]         samp_cnt_q, samp_cnt_d;
  logic [1:0]             smp_q, smp_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             data_q, data_d;
  logic                   par_bit_q, par_bit_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   overrun_q, overrun_d;
  logic [10:0]            mem_q [FIFO_DEPTH];

  logic        rx_s, start_det, tick, vote_now, bit_end, vote, last_data;
  logic        push_req, exp_par, full, empty, pop, do_push, wr_en;
  logic [10:0] entry, head;
  logic [8:0]  trig_raw, trig_eff;

  assign rx_s      = sync_q[SYNC_STAGES-1];
  assign start_det = (state_q == S_IDLE) && !rx_s && (baud_div != 16'd0);
  assign tick      = (state_q != S_IDLE) && (div_cnt_q == baud_q - 16'd1);
  assign vote_now  = tick && (samp_cnt_q == MID_HI);
  assign bit_end   = tick && (samp_cnt_q == LAST);
  assign vote      = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
  assign last_data = (bit_cnt_q == (3'd4 + {1'b0, word_length}));

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= {SYNC_STAGES{1'b1}};
      state_q    <= S_IDLE;
      div_cnt_q  <= '0;
      baud_q     <= '0;
      samp_cnt_q <= '0;
      smp_q      <= '0;
      bit_cnt_q  <= '0;
      data_q     <= '0;
      par_bit_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      baud_q     <= baud_d;
      samp_cnt_q <= samp_cnt_d;
      smp_q      <= smp_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      par_bit_q  <= par_bit_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (start_det) state_d = S_START;
      S_START: begin
        if (vote_now && vote) state_d = S_IDLE;
        else if (bit_end)     state_d = S_DATA;
      end
      S_DATA:      if (bit_end && last_data) state_d = parity[0] ? S_PARITY : S_STOP;
      S_PARITY:    if (bit_end) state_d = S_STOP;
      S_STOP:      if (vote_now) state_d = vote ? S_IDLE : S_WAIT_HIGH;
      S_WAIT_HIGH: if (rx_s) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    push_req = (state_q == S_STOP) && vote_now;
    rx_busy  = (state_q != S_IDLE);
  end

  // Bit timing restarts on the start edge; baud_div is captured there so a
  // mid-frame change only affects the following frame.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], rx};
    div_cnt_d  = div_cnt_q;
    baud_d     = baud_q;
    samp_cnt_d = samp_cnt_q;
    smp_d      = smp_q;
    bit_cnt_d  = bit_cnt_q;
    data_d     = data_q;
    par_bit_d  = par_bit_q;
    if (start_det) begin
      div_cnt_d  = '0;
      baud_d     = baud_div;
      samp_cnt_d = '0;
      bit_cnt_d  = '0;
      data_d     = '0;
      par_bit_d  = 1'b0;
    end else if (state_q != S_IDLE) begin
      div_cnt_d = tick ? 16'd0 : div_cnt_q + 16'd1;
      if (tick) samp_cnt_d = bit_end ? '0 : samp_cnt_q + 1'b1;
      if (tick && samp_cnt_q == MID_LO) smp_d[0] = rx_s;
      if (tick && samp_cnt_q == MID)    smp_d[1] = rx_s;
      if (vote_now && state_q == S_DATA)   data_d[bit_cnt_q] = vote;
      if (vote_now && state_q == S_PARITY) par_bit_d = vote;
      if (bit_end && state_q == S_DATA)    bit_cnt_d = bit_cnt_q + 3'd1;
    end
  end

  // Unused upper data bits stay zero, so the reduction covers active bits only.
  always_comb begin
    exp_par = parity[2] ? ~parity[1] : (parity[1] ? ^data_q : ~^data_q);
    entry   = {(data_q == 8'd0) && (!parity[0] || !par_bit_q) && !vote,
               !vote,
               parity[0] && (par_bit_q != exp_par),
               data_q};
  end

  always_comb begin
    full      = (count_q == CW'(FIFO_DEPTH));
    empty     = (count_q == '0);
    pop       = read_flag && !empty;
    do_push   = push_req && !full;
    wr_en     = do_push && !fifo_clear;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (fifo_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(pop);
    end
    if (push_req && full)             overrun_d = 1'b1;
    else if (read_flag || fifo_clear) overrun_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= entry;
  end

  always_comb begin
    head = empty ? 11'd0 : mem_q[rd_ptr_q];
    case (trig_level)
      2'b00:   trig_raw = 9'd1;
      2'b01:   trig_raw = 9'd4;
      2'b10:   trig_raw = 9'd8;
      default: trig_raw = 9'd14;
    endcase
    trig_eff = (trig_raw > 9'(FIFO_DEPTH)) ? 9'(FIFO_DEPTH) : trig_raw;
  end

  assign po_rx_data    = head[7:0];
  assign parity_error  = head[8];
  assign framing_error = head[9];
  assign break_int     = head[10];
  assign data_ready    = !empty;
  assign overrun_error = overrun_q;
  assign fifo_count    = count_q;
  assign rx_int        = (9'(count_q) >= trig_eff);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// tb_uart_rx_fifo : self-checking bench for uart_rx_fifo (queue-based model)
// Revision        : 1.0
// ============================================================================
module tb_uart_rx_fifo;

  localparam int DEPTH = 4;
  localparam int OS    = 16;
  localparam int BAUD  = 4;
  localparam int BIT   = BAUD * OS;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [1:0]               word_length = 2'd3;
  logic [15:0]              baud_div = 16'(BAUD);
  logic [2:0]               parity = 3'd0;
  logic                     rx = 1'b1;
  logic                     read_flag = 1'b0;
  logic                     fifo_clear = 1'b0;
  logic [1:0]               trig_level = 2'd0;
  logic [7:0]               po_rx_data;
  logic                     parity_error, framing_error, break_int, data_ready;
  logic                     overrun_error, rx_int, rx_busy;
  logic [$clog2(DEPTH):0]   fifo_count;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          last_rise = -1;
  logic [10:0] model_q[$];
  logic        model_ovr = 1'b0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.FIFO_DEPTH(DEPTH), .OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .word_length(word_length), .baud_div(baud_div),
    .parity(parity), .rx(rx), .read_flag(read_flag), .fifo_clear(fifo_clear),
    .trig_level(trig_level), .po_rx_data(po_rx_data), .parity_error(parity_error),
    .framing_error(framing_error), .break_int(break_int), .data_ready(data_ready),
    .overrun_error(overrun_error), .fifo_count(fifo_count), .rx_int(rx_int),
    .rx_busy(rx_busy)
  );

  function automatic logic [10:0] exp_entry(input logic [7:0] d, input logic [1:0] wl,
                                            input logic [2:0] par, input logic pbit,
                                            input logic stop);
    int          n;
    int          ones;
    logic [7:0]  m;
    logic        pexp, pe, brk;
    n    = 5 + int'(wl);
    m    = d & 8'((1 << n) - 1);
    ones = $countones(m);
    if (par[2])      pexp = ~par[1];
    else if (par[1]) pexp = (ones % 2 == 1);
    else             pexp = (ones % 2 == 0);
    pe  = par[0] && (pbit != pexp);
    brk = (m == 8'd0) && (!par[0] || !pbit) && !stop;
    return {brk, !stop, pe, m};
  endfunction

  function automatic void model_push(input logic [10:0] e);
    if (model_q.size() >= DEPTH) model_ovr = 1'b1;
    else model_q.push_back(e);
  endfunction

  function automatic logic [10:0] head_obs();
    return {break_int, framing_error, parity_error, po_rx_data};
  endfunction

  // Drives one frame; reports the stop-bit cycle at which fifo_count moved.
  task automatic send_frame(input logic [7:0] d, input logic [1:0] wl, input logic [2:0] par,
                            input logic pbit, input logic stop, input int pop_at,
                            output int rise);
    int n;
    int prev;
    n           = 5 + int'(wl);
    rise        = -1;
    word_length = wl;
    parity      = par;
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      rx = d[i];
      repeat (BIT) @(negedge clk);
    end
    if (par[0]) begin
      rx = pbit;
      repeat (BIT) @(negedge clk);
    end
    rx   = stop;
    prev = int'(fifo_count);
    for (int i = 0; i < BIT; i++) begin
      @(negedge clk);
      if (rise < 0 && int'(fifo_count) != prev) rise = i;
      read_flag = (i == pop_at - 1);
    end
    read_flag = 1'b0;
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
  endtask

  task automatic pulse_read();
    @(negedge clk);
    read_flag = 1'b1;
    @(negedge clk);
    read_flag = 1'b0;
  endtask

  task automatic test_reset();
    repeat (5) @(negedge clk);
    total_cnt++;
    if ({po_rx_data, parity_error, framing_error, break_int, data_ready, overrun_error,
         fifo_count, rx_int, rx_busy} !== '0)
      $display("FAIL reset_outputs: got data=%h dr=%b cnt=%0d busy=%b int=%b, expected all 0",
               po_rx_data, data_ready, fifo_count, rx_busy, rx_int);
    else pass_cnt++;
    rst = 1'b0;
    rx  = 1'b0;
    repeat (3 * BIT) @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (14 * BIT) @(negedge clk);
    total_cnt++;
    if ({fifo_count, rx_busy} !== '0)
      $display("FAIL reset_midframe: got cnt=%0d busy=%b, expected 0 0", fifo_count, rx_busy);
    else pass_cnt++;
  endtask

  task automatic test_8n1();
    int r;
    trig_level = 2'd0;
    send_frame(8'hA5, 2'd3, 3'd0, 1'b0, 1'b1, -1, r);
    model_push(exp_entry(8'hA5, 2'd3, 3'd0, 1'b0, 1'b1));
    last_rise = r;
    total_cnt++;
    if (!(r >= (OS / 2) * BAUD && r <= (OS / 2 + 2) * BAUD + 4))
      $display("FAIL 8n1_latency: push at stop cycle %0d, expected %0d..%0d",
               r, (OS / 2) * BAUD, (OS / 2 + 2) * BAUD + 4);
    else pass_cnt++;
    total_cnt++;
    if (head_obs() !== model_q[0])
      $display("FAIL 8n1_head: got %h expected %h", head_obs(), model_q[0]);
    else pass_cnt++;
    total_cnt++;
    if ({data_ready, rx_int} !== 2'b11)
      $display("FAIL 8n1_ready_int: got dr=%b int=%b expected 1 1", data_ready, rx_int);
    else pass_cnt++;
    trig_level = 2'd3;
    @(negedge clk);
    total_cnt++;
    if (rx_int !== 1'b0) $display("FAIL trig_clamp_low: got %b expected 0", rx_int);
    else pass_cnt++;
    pulse_read();
    void'(model_q.pop_front());
    total_cnt++;
    if ({data_ready, po_rx_data} !== 9'd0)
      $display("FAIL 8n1_empty: got dr=%b data=%h expected 0 00", data_ready, po_rx_data);
    else pass_cnt++;
  endtask

  task automatic test_parity();
    int r;
    send_frame(8'h35, 2'd2, 3'b011, 1'b1, 1'b1, -1, r);
    model_push(exp_entry(8'h35, 2'd2, 3'b011, 1'b1, 1'b1));
    send_frame(8'h35, 2'd2, 3'b011, 1'b0, 1'b1, -1, r);
    model_push(exp_entry(8'h35, 2'd2, 3'b011, 1'b0, 1'b1));
    send_frame(8'h1F, 2'd0, 3'b101, 1'b0, 1'b1, -1, r);
    model_push(exp_entry(8'h1F, 2'd0, 3'b101, 1'b0, 1'b1));
    while (model_q.size() > 0) begin
      total_cnt++;
      if (head_obs() !== model_q[0])
        $display("FAIL parity_head: got %h expected %h", head_obs(), model_q[0]);
      else pass_cnt++;
      pulse_read();
      void'(model_q.pop_front());
    end
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    repeat (3 * BAUD) @(negedge clk);
    rx = 1'b1;
    total_cnt++;
    if (rx_busy !== 1'b1) $display("FAIL glitch_busy: got %b expected 1", rx_busy);
    else pass_cnt++;
    repeat (2 * BIT) @(negedge clk);
    total_cnt++;
    if ({rx_busy, fifo_count} !== '0)
      $display("FAIL glitch_idle: got busy=%b cnt=%0d expected 0 0", rx_busy, fifo_count);
    else pass_cnt++;
  endtask

  task automatic test_break();
    int r;
    word_length = 2'd3;
    parity      = 3'd0;
    rx = 1'b0;
    repeat (25 * BIT) @(negedge clk);
    model_push(11'b110_0000_0000);
    total_cnt++;
    if (int'(fifo_count) !== 1 || head_obs() !== model_q[0])
      $display("FAIL break_entry: got cnt=%0d head=%h expected 1 %h",
               fifo_count, head_obs(), model_q[0]);
    else pass_cnt++;
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    total_cnt++;
    if (int'(fifo_count) !== 1) $display("FAIL break_single: got %0d expected 1", fifo_count);
    else pass_cnt++;
    send_frame(8'h5A, 2'd3, 3'd0, 1'b0, 1'b1, -1, r);
    model_push(exp_entry(8'h5A, 2'd3, 3'd0, 1'b0, 1'b1));
    while (model_q.size() > 0) begin
      total_cnt++;
      if (head_obs() !== model_q[0])
        $display("FAIL break_drain: got %h expected %h", head_obs(), model_q[0]);
      else pass_cnt++;
      pulse_read();
      void'(model_q.pop_front());
    end
  endtask

  task automatic test_overrun();
    int r;
    trig_level = 2'd3;
    for (int k = 1; k <= 5; k++) begin
      send_frame(8'(k), 2'd3, 3'd0, 1'b0, 1'b1, -1, r);
      model_push(exp_entry(8'(k), 2'd3, 3'd0, 1'b0, 1'b1));
    end
    total_cnt++;
    if ({int'(fifo_count), overrun_error, rx_int} !== {model_q.size(), model_ovr, 1'b1})
      $display("FAIL overrun_full: got cnt=%0d ovr=%b int=%b expected %0d %b 1",
               fifo_count, overrun_error, rx_int, model_q.size(), model_ovr);
    else pass_cnt++;
    for (int k = 0; k < 2; k++) begin
      total_cnt++;
      if (head_obs() !== model_q[0])
        $display("FAIL overrun_read: got %h expected %h", head_obs(), model_q[0]);
      else pass_cnt++;
      pulse_read();
      void'(model_q.pop_front());
      model_ovr = 1'b0;
      total_cnt++;
      if (overrun_error !== model_ovr)
        $display("FAIL overrun_clear_read: got %b expected %b", overrun_error, model_ovr);
      else pass_cnt++;
    end
    send_frame(8'h06, 2'd3, 3'd0, 1'b0, 1'b1, last_rise, r);
    void'(model_q.pop_front());
    model_push(exp_entry(8'h06, 2'd3, 3'd0, 1'b0, 1'b1));
    total_cnt++;
    if (int'(fifo_count) !== model_q.size() || head_obs() !== model_q[0])
      $display("FAIL push_pop_same: got cnt=%0d head=%h expected %0d %h",
               fifo_count, head_obs(), model_q.size(), model_q[0]);
    else pass_cnt++;
    for (int k = 7; k <= 9; k++) begin
      send_frame(8'(k), 2'd3, 3'd0, 1'b0, 1'b1, -1, r);
      model_push(exp_entry(8'(k), 2'd3, 3'd0, 1'b0, 1'b1));
    end
    @(negedge clk);
    fifo_clear = 1'b1;
    @(negedge clk);
    fifo_clear = 1'b0;
    model_q.delete();
    total_cnt++;
    if ({fifo_count, overrun_error} !== '0)
      $display("FAIL clear_overrun: got cnt=%0d ovr=%b expected 0 0", fifo_count, overrun_error);
    else pass_cnt++;
    model_ovr = 1'b0;
  endtask

  task automatic test_clear_midframe();
    int r;
    for (int k = 0; k < 3; k++) send_frame(8'(8'h11 + k), 2'd3, 3'd0, 1'b0, 1'b1, -1, r);
    fork
      send_frame(8'h14, 2'd3, 3'd0, 1'b0, 1'b1, -1, r);
      begin
        repeat (3 * BIT) @(negedge clk);
        fifo_clear = 1'b1;
        @(negedge clk);
        fifo_clear = 1'b0;
      end
    join
    model_push(exp_entry(8'h14, 2'd3, 3'd0, 1'b0, 1'b1));
    total_cnt++;
    if ({int'(fifo_count), head_obs(), overrun_error} !== {model_q.size(), model_q[0], 1'b0})
      $display("FAIL clear_midframe: got cnt=%0d head=%h ovr=%b expected %0d %h 0",
               fifo_count, head_obs(), overrun_error, model_q.size(), model_q[0]);
    else pass_cnt++;
    pulse_read();
    void'(model_q.pop_front());
  endtask

  task automatic test_random();
    int          r;
    logic [7:0]  d;
    logic [1:0]  wl;
    logic [2:0]  par;
    logic        pb, st;
    for (int k = 0; k < 14; k++) begin
      d   = 8'($urandom);
      wl  = 2'($urandom);
      par = 3'($urandom);
      pb  = 1'($urandom);
      st  = ($urandom_range(0, 5) != 0);
      if (k == 3) begin d = 8'h00; pb = 1'b0; st = 1'b0; end
      send_frame(d, wl, par, pb, st, -1, r);
      model_push(exp_entry(d, wl, par, pb, st));
      total_cnt++;
      if (int'(fifo_count) !== model_q.size() || head_obs() !== model_q[0])
        $display("FAIL random_frame%0d: got cnt=%0d head=%h expected %0d %h",
                 k, fifo_count, head_obs(), model_q.size(), model_q[0]);
      else pass_cnt++;
      if (model_q.size() >= 3 || $urandom_range(0, 1) == 1) begin
        pulse_read();
        void'(model_q.pop_front());
      end
    end
    while (model_q.size() > 0) begin
      total_cnt++;
      if (head_obs() !== model_q[0])
        $display("FAIL random_drain: got %h expected %h", head_obs(), model_q[0]);
      else pass_cnt++;
      pulse_read();
      void'(model_q.pop_front());
    end
    total_cnt++;
    if (data_ready !== 1'b0) $display("FAIL random_empty: got dr=%b expected 0", data_ready);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_glitch();
    test_break();
    test_overrun();
    test_clear_midframe();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
